// File: rtl/mips_mem_arbiter.sv
// Shares one single-port memory between the MIPS fetch and data ports.
// Fixed-latency access sequencer with data-priority arbitration and starvation guard.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch winner on any request
// ISSUE | m_en strobe for one cycle with latched address/data
// WAIT  | down-count MEM_LAT cycles; capture m_rdata at terminal count
// RESP  | one-cycle ack to the winner; requests ignored
module mips_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int MEM_LAT     = 2,
  parameter int MAX_DSTREAK = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          stall,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int CW  = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int DSW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DSW-1:0] dstreak_q, dstreak_d;
  logic           win_d_q, win_d_d;
  logic           wr_q, wr_d;
  logic           m_en_q, m_en_d;
  logic           m_we_q, m_we_d;
  logic [AW-1:0]  m_addr_q, m_addr_d;
  logic [DW-1:0]  m_wdata_q, m_wdata_d;
  logic           i_ack_q, i_ack_d;
  logic           d_ack_q, d_ack_d;
  logic [DW-1:0]  i_rdata_q, i_rdata_d;
  logic [DW-1:0]  d_rdata_q, d_rdata_d;
  logic           grant_d;

  // Data normally wins a contest; once it has won MAX_DSTREAK contests in a row, fetch goes.
  assign grant_d = d_req & ~(i_req & (dstreak_q == DSW'(MAX_DSTREAK)));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dstreak_d = dstreak_q;
    win_d_d   = win_d_q;
    wr_d      = wr_q;
    m_en_d    = m_en_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req | d_req) begin
          win_d_d   = grant_d;
          wr_d      = grant_d & d_we;
          m_en_d    = 1'b1;
          m_we_d    = grant_d & d_we;
          m_addr_d  = grant_d ? d_addr : i_addr;
          m_wdata_d = grant_d ? d_wdata : '0;
          if (grant_d & i_req) dstreak_d = dstreak_q + DSW'(1);
          else                 dstreak_d = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_en_d  = 1'b0;
        m_we_d  = 1'b0;
        cnt_d   = CW'(MEM_LAT);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          if (!wr_q) begin
            if (win_d_q) d_rdata_d = m_rdata;
            else         i_rdata_d = m_rdata;
          end
          if (win_d_q) d_ack_d = 1'b1;
          else         i_ack_d = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      dstreak_q <= '0;
      win_d_q   <= 1'b0;
      wr_q      <= 1'b0;
      m_en_q    <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dstreak_q <= dstreak_d;
      win_d_q   <= win_d_d;
      wr_q      <= wr_d;
      m_en_q    <= m_en_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_en    = m_en_q;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign i_ack   = i_ack_q;
  assign d_ack   = d_ack_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign stall   = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Scoreboard bench for mips_mem_arbiter: directed vectors push expected strobes/acks,
// monitors pop and compare when the DUT presents them.
module tb_mips_mem_arbiter;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } men_t;

  typedef struct {
    int          cyc;
    logic        is_d;
    logic [31:0] rdata;
  } ack_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, m_en, m_we, stall, busy;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;

  logic        b_reset = 1'b0;
  logic        b_i_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
  logic [31:0] b_i_addr = '0, b_d_addr = '0, b_d_wdata = '0;
  logic        b_i_ack, b_d_ack, b_m_en, b_m_we, b_stall, b_busy;
  logic [31:0] b_i_rdata, b_d_rdata, b_m_addr, b_m_wdata, b_m_rdata;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   b_done = 1'b0;
  men_t men_q[$], b_men_q[$];
  ack_t ack_q[$], b_ack_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2), .MAX_DSTREAK(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .stall(stall), .busy(busy)
  );

  mips_mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_DSTREAK(4)) dut_b (
    .clk(clk), .reset(b_reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_ack(b_i_ack), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_ack(b_d_ack), .d_rdata(b_d_rdata),
    .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata),
    .stall(b_stall), .busy(b_busy)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    case (a)
      32'h0040_0000: return 32'h8C01_0004;
      32'h0040_0004: return 32'h2002_0005;
      32'h1001_0000: return 32'h0000_002A;
      32'h1001_0008: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_A5A5;
    endcase
  endfunction

  // Memory models: read data is valid only in the single cycle MEM_LAT after m_en.
  logic        va0 = 1'b0, va1 = 1'b0, vb0 = 1'b0;
  logic [31:0] pa0 = '0, pa1 = '0, pb0 = '0;
  always @(posedge clk) begin
    va0 <= m_en & ~m_we;
    pa0 <= mem_val(m_addr);
    va1 <= va0;
    pa1 <= pa0;
    vb0 <= b_m_en & ~b_m_we;
    pb0 <= mem_val(b_m_addr);
  end
  assign m_rdata   = va1 ? pa1 : 32'hBAD0_BAD0;
  assign b_m_rdata = vb0 ? pb0 : 32'hBAD0_BAD0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic unexpected(input string nm);
    n_total++;
    $display("FAIL %s: unexpected DUT event at cycle %0d", nm, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_men(input int c, input logic [31:0] a, input logic we, input logic [31:0] wd);
    men_q.push_back('{cyc: c, addr: a, we: we, wdata: wd});
  endtask

  task automatic push_ack(input int c, input logic is_d, input logic [31:0] rd);
    ack_q.push_back('{cyc: c, is_d: is_d, rdata: rd});
  endtask

  always @(negedge clk) begin
    men_t m;
    ack_t a;
    if (m_we) chk("m_we_needs_m_en", {31'd0, m_en}, 32'd1);
    if (i_ack) chk("acks_exclusive", {31'd0, d_ack}, 32'd0);
    if (m_en) begin
      if (men_q.size() == 0) unexpected("m_en");
      else begin
        m = men_q.pop_front();
        chk("m_en_cycle", cyc, m.cyc);
        chk("m_addr", m_addr, m.addr);
        chk("m_we", {31'd0, m_we}, {31'd0, m.we});
        if (m.we) chk("m_wdata", m_wdata, m.wdata);
      end
    end
    if (i_ack | d_ack) begin
      if (ack_q.size() == 0) unexpected("ack");
      else begin
        a = ack_q.pop_front();
        chk("ack_cycle", cyc, a.cyc);
        chk("ack_is_data", {31'd0, d_ack}, {31'd0, a.is_d});
        chk("ack_rdata", a.is_d ? d_rdata : i_rdata, a.rdata);
      end
    end
  end

  always @(negedge clk) begin
    men_t m;
    ack_t a;
    if (b_m_en) begin
      if (b_men_q.size() == 0) unexpected("b_m_en");
      else begin
        m = b_men_q.pop_front();
        chk("b_m_en_cycle", cyc, m.cyc);
        chk("b_m_addr", b_m_addr, m.addr);
      end
    end
    if (b_i_ack | b_d_ack) begin
      if (b_ack_q.size() == 0) unexpected("b_ack");
      else begin
        a = b_ack_q.pop_front();
        chk("b_ack_cycle", cyc, a.cyc);
        chk("b_ack_is_data", {31'd0, b_d_ack}, {31'd0, a.is_d});
        chk("b_ack_rdata", b_d_rdata, a.rdata);
      end
    end
  end

  // MEM_LAT=1 instance: back-to-back data reads spaced 4 cycles.
  initial begin
    int c;
    tick(3);
    b_reset = 1'b1;
    tick(1);
    c = cyc;
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h1001_0000;
    b_men_q.push_back('{cyc: c + 1, addr: 32'h1001_0000, we: 1'b0, wdata: 32'h0});
    b_ack_q.push_back('{cyc: c + 3, is_d: 1'b1, rdata: 32'h0000_002A});
    tick(3);
    b_d_addr = 32'h1001_0008;
    b_men_q.push_back('{cyc: c + 5, addr: 32'h1001_0008, we: 1'b0, wdata: 32'h0});
    b_ack_q.push_back('{cyc: c + 7, is_d: 1'b1, rdata: 32'h1234_5678});
    tick(4);
    b_d_req = 1'b0;
    tick(2);
    b_done = 1'b1;
  end

  initial begin
    int c, r;
    tick(3);
    chk("rst_m_en", {31'd0, m_en}, 32'd0);
    chk("rst_m_we", {31'd0, m_we}, 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_i_ack_d_ack", {30'd0, i_ack, d_ack}, 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    tick(1);

    // single fetch
    c = cyc;
    i_req = 1'b1; i_addr = 32'h0040_0000;
    push_men(c + 1, 32'h0040_0000, 1'b0, 32'h0);
    push_ack(c + 4, 1'b0, 32'h8C01_0004);
    #1 chk("t1_stall", {31'd0, stall}, 32'd1);
    tick(4);
    i_req = 1'b0;
    tick(1);
    chk("t1_busy_after", {31'd0, busy}, 32'd0);

    // contested: data first, then fetch
    c = cyc;
    i_req = 1'b1; i_addr = 32'h0040_0004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h1001_0000;
    push_men(c + 1, 32'h1001_0000, 1'b0, 32'h0);
    push_ack(c + 4, 1'b1, 32'h0000_002A);
    push_men(c + 6, 32'h0040_0004, 1'b0, 32'h0);
    push_ack(c + 9, 1'b0, 32'h2002_0005);
    tick(1);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    tick(3);
    chk("t2_stall_at_dack", {31'd0, stall}, 32'd1);
    d_req = 1'b0;
    tick(5);
    chk("t2_stall_at_iack", {31'd0, stall}, 32'd0);
    i_req = 1'b0;
    tick(1);

    // data write; d_rdata keeps 0x2A
    c = cyc;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h1001_0004; d_wdata = 32'hDEAD_BEEF;
    push_men(c + 1, 32'h1001_0004, 1'b1, 32'hDEAD_BEEF);
    push_ack(c + 4, 1'b1, 32'h0000_002A);
    tick(4);
    d_req = 1'b0; d_we = 1'b0;
    tick(1);

    // continuous contention: D,D,D,D,I,D,D,D,D,I
    c = cyc;
    i_req = 1'b1; i_addr = 32'h0040_0000;
    d_req = 1'b1; d_addr = 32'h1001_0008;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 != 4) begin
        push_men(c + 5 * k + 1, 32'h1001_0008, 1'b0, 32'h0);
        push_ack(c + 5 * k + 4, 1'b1, 32'h1234_5678);
      end else begin
        push_men(c + 5 * k + 1, 32'h0040_0000, 1'b0, 32'h0);
        push_ack(c + 5 * k + 4, 1'b0, 32'h8C01_0004);
      end
    end
    tick(49);
    i_req = 1'b0; d_req = 1'b0;
    tick(1);

    // reset during WAIT of a fetch, then re-service
    c = cyc;
    i_req = 1'b1; i_addr = 32'h0040_0004;
    push_men(c + 1, 32'h0040_0004, 1'b0, 32'h0);
    tick(2);
    chk("t5_busy_in_wait", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("t5_async_m_en", {31'd0, m_en}, 32'd0);
    chk("t5_async_i_ack", {31'd0, i_ack}, 32'd0);
    chk("t5_async_busy", {31'd0, busy}, 32'd0);
    chk("t5_async_m_addr", m_addr, 32'd0);
    tick(2);
    reset = 1'b1;
    r = cyc;
    push_men(r + 1, 32'h0040_0004, 1'b0, 32'h0);
    push_ack(r + 4, 1'b0, 32'h2002_0005);
    tick(4);
    i_req = 1'b0;
    tick(3);

    for (int w = 0; w < 50 && !b_done; w++) tick(1);
    chk("b_bench_done", {31'd0, b_done}, 32'd1);
    chk("men_q_drained", men_q.size(), 32'd0);
    chk("ack_q_drained", ack_q.size(), 32'd0);
    chk("b_men_q_drained", b_men_q.size(), 32'd0);
    chk("b_ack_q_drained", b_ack_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Shares one single-port unified memory between the processor's instruction-fetch port and data-access port.
- Arbitrates between the two requesters and sequences each memory transaction through a fixed-latency FSM.
- Returns read data to the requester with a one-cycle ack pulse and provides a stall signal to the core.
- Sits between the MIPS core's pc/instr and aluout/writedata/readdata interfaces and the shared memory.

Parameters:
AW, 32, address width
DW, 32, data width
MEM_LAT, 2, cycles from m_en high to m_rdata valid (must be >= 1)
MAX_DSTREAK, 4, consecutive contested data grants before instruction is forced to win (must be >= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
i_req  in  1  instruction fetch request, held until i_ack
i_addr  in  AW  fetch address
i_ack  out  1  one-cycle pulse, fetch complete
i_rdata  out  DW  fetched word, registered
d_req  in  1  data request, held until d_ack
d_we  in  1  1=write, 0=read
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  DW  load data, registered
m_en  out  1  memory access strobe, one cycle per transaction
m_we  out  1  memory write enable, high only together with m_en
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en
stall  out  1  (i_req & ~i_ack) | (d_req & ~d_ack), combinational
busy  out  1  high whenever FSM is not IDLE

Behaviour:
- One clock domain (clk). reset is asynchronous and active-low. While reset==0:
  - FSM goes to IDLE; dstreak=0.
  - All registered outputs are 0: m_en, m_we, m_addr, m_wdata, i_ack, d_ack, i_rdata, d_rdata.
  - busy=0.
- Reset mid-transaction abandons the access. Requesters still holding req are re-serviced from IDLE after reset release.
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is sampled at edge t, latch winner, addr, we and wdata, then go to ISSUE.
  - Otherwise remain in IDLE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesting: data wins unless dstreak==MAX_DSTREAK, in which case instruction wins.
  - dstreak increments when data wins while i_req=1.
  - dstreak clears when instruction wins, or when data wins with i_req=0.
- ISSUE (cycle t+1):
  - m_en=1; m_addr, m_wdata and m_we (data write only) come from latched values.
  - Instruction accesses are always reads.
  - Next state is WAIT with wait counter = MEM_LAT.
- WAIT:
  - m_en=0, m_we=0; m_addr and m_wdata hold their values.
  - Counter decrements each cycle.
  - On the edge ending cycle t+1+MEM_LAT, capture m_rdata into the winner's rdata register (reads only), then go to RESP.
- RESP (cycle t+2+MEM_LAT):
  - Winner's ack=1 for exactly this cycle.
  - Requests are ignored in RESP; the requester's req is still high here. Next state is IDLE.
- Timing:
  - Total latency from req sampled to ack is MEM_LAT+2 cycles.
  - Minimum spacing between back-to-back transactions is MEM_LAT+3 cycles.
- Writes follow the same timing. d_rdata is unchanged on write ack.
- i_rdata and d_rdata hold their last captured values between acks.
- The arbiter latches request fields at grant. Requesters must keep addr and data stable until ack anyway.
- A req that drops before being granted is simply not serviced. A req that drops after grant does not abort the access; ack still pulses.
- Never more than one access is in flight. i_ack and d_ack are never high together.

Test Plan:
1. MEM_LAT=2. i_req=1, i_addr=0x00400000 at edge t; memory returns 0x8C010004 at t+3 -> m_en=1 with m_addr=0x00400000 in cycle t+1 only; i_ack=1 and i_rdata=0x8C010004 in cycle t+4; busy=0 at t+5.
2. i_req and d_req (read, 0x10010000, memory returns 0x0000002A) both rise at t -> d_ack at t+4 with d_rdata=0x2A; instruction granted at t+5; i_ack at t+9; stall high until each ack.
3. d_req=1, d_we=1, d_addr=0x10010004, d_wdata=0xDEADBEEF -> cycle t+1 has m_en=m_we=1, m_addr=0x10010004, m_wdata=0xDEADBEEF; d_ack at t+4; d_rdata unchanged.
4. MAX_DSTREAK=4, i_req and d_req held high continuously (requesters re-request after each ack) -> grant order D,D,D,D,I,D,D,D,D,I; m_we never high without m_en.
5. reset driven 0 during WAIT of an instruction fetch -> m_en, i_ack and busy read 0 immediately, asynchronously; after release with i_req still 1, a fresh m_en is issued one cycle after the first IDLE edge and i_ack follows MEM_LAT+2 cycles after grant.
6. MEM_LAT=1, single d read -> m_en at t+1, capture at end of t+2, d_ack at t+3; back-to-back reads are spaced 4 cycles apart.
